// File: rtl/mips_stim_sequencer.sv
// Stimulus sequencer for a MIPS CPU under test: serves a loadable program on the
// instruction port, sequences CPU reset and run, and checks register_v0 at the end.
module mips_stim_sequencer #(
   parameter int unsigned DEPTH          = 16,
   parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   localparam int unsigned AW            = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          start,
   input  logic [15:0]   run_cycles,
   input  logic [31:0]   expect_v0,
   output logic          dut_reset,
   output logic          dut_clk_enable,
   input  logic          dut_active,
   input  logic [31:0]   dut_register_v0,
   input  logic [31:0]   dut_instr_address,
   output logic [31:0]   dut_instr_readdata,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [1:0]    fail_code,
   output logic [15:0]   cycle_count
);

   localparam int unsigned RCW = $clog2(RESET_CYCLES) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RST   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [31:0]    mem [DEPTH];
   logic [31:0]    off;
   logic           oor_flag;

   logic [2:0]     state, state_nxt;
   logic [RCW-1:0] rst_cnt, rst_cnt_nxt;
   logic [31:0]    exp_q, exp_nxt;
   logic [15:0]    run_q, run_nxt;
   logic [15:0]    count_nxt;
   logic [16:0]    count_inc;
   logic           pass_nxt;
   logic [1:0]     code_nxt;
   logic           busy_nxt, done_nxt, dut_reset_nxt, clk_en_nxt;

   // Zero-latency fetch; anything outside the aligned program window reads as a NOP.
   always_comb begin
      off                = dut_instr_address - RESET_VECTOR;
      oor_flag           = (off[1:0] != 2'b00) || (32'(off[31:2]) >= DEPTH);
      dut_instr_readdata = oor_flag ? 32'h0 : mem[off[AW+1:2]];
   end

   // Program store, writable only while idle; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (load_en && state == S_IDLE) begin
         mem[load_addr] <= load_data;
      end
   end

   assign count_inc = {1'b0, cycle_count} + 17'd1;

   always_comb begin
      state_nxt   = state;
      rst_cnt_nxt = rst_cnt;
      exp_nxt     = exp_q;
      run_nxt     = run_q;
      count_nxt   = cycle_count;
      pass_nxt    = pass;
      code_nxt    = fail_code;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_RST;
               rst_cnt_nxt = '0;
               exp_nxt     = expect_v0;
               run_nxt     = run_cycles;
               count_nxt   = '0;
               pass_nxt    = 1'b0;
               code_nxt    = 2'd0;
            end
         end
         S_RST: begin
            if (rst_cnt == RCW'(RESET_CYCLES - 1)) begin
               state_nxt = S_RUN;
            end else begin
               rst_cnt_nxt = rst_cnt + RCW'(1);
            end
         end
         S_RUN: begin
            count_nxt = (cycle_count == 16'hFFFF) ? cycle_count : count_inc[15:0];
            if (oor_flag && dut_active) begin
               state_nxt = S_DONE;
               code_nxt  = 2'd3;
            end else if (32'(count_inc) == TIMEOUT_CYCLES) begin
               // Timeout reports the last completed count rather than the limit.
               state_nxt = S_DONE;
               code_nxt  = 2'd2;
               count_nxt = cycle_count;
            end else if (run_q != 16'd0 && count_inc == {1'b0, run_q}) begin
               state_nxt = S_CHECK;
            end else if (run_q == 16'd0 && !dut_active && cycle_count != 16'd0) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            state_nxt = S_DONE;
            if (dut_register_v0 == exp_q) begin
               pass_nxt = 1'b1;
               code_nxt = 2'd0;
            end else begin
               pass_nxt = 1'b0;
               code_nxt = 2'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state register.
      busy_nxt      = (state_nxt == S_RST) || (state_nxt == S_RUN) || (state_nxt == S_CHECK);
      done_nxt      = (state_nxt == S_DONE);
      dut_reset_nxt = !((state_nxt == S_RUN) || (state_nxt == S_CHECK));
      clk_en_nxt    = (state_nxt == S_RST) || (state_nxt == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         rst_cnt        <= '0;
         exp_q          <= '0;
         run_q          <= '0;
         cycle_count    <= '0;
         pass           <= 1'b0;
         fail_code      <= 2'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         dut_reset      <= 1'b1;
         dut_clk_enable <= 1'b0;
      end else begin
         state          <= state_nxt;
         rst_cnt        <= rst_cnt_nxt;
         exp_q          <= exp_nxt;
         run_q          <= run_nxt;
         cycle_count    <= count_nxt;
         pass           <= pass_nxt;
         fail_code      <= code_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         dut_reset      <= dut_reset_nxt;
         dut_clk_enable <= clk_en_nxt;
      end
   end

endmodule

// File: tb/tb_mips_stim_sequencer.sv
// Directed plus randomized bench for mips_stim_sequencer with a stub CPU and a
// per-test outcome model derived from the sequencing rules.
module tb_mips_stim_sequencer;

   localparam int          N  = 2;
   localparam int          TO = 20;
   localparam int          D  = 16;
   localparam logic [31:0] RV = 32'hBFC00000;

   typedef struct packed {
      int         x;
      bit         chk;
      logic [1:0] code;
      int         cnt;
   } res_t;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [31:0] load_data;
   logic        start;
   logic [15:0] run_cycles;
   logic [31:0] expect_v0;
   logic        dut_reset;
   logic        dut_clk_enable;
   logic        dut_active;
   logic [31:0] dut_register_v0;
   logic [31:0] dut_instr_address;
   logic [31:0] dut_instr_readdata;
   logic        busy;
   logic        done;
   logic        pass;
   logic [1:0]  fail_code;
   logic [15:0] cycle_count;

   logic [31:0] mem_m [D];
   int          checks = 0;
   int          errors = 0;

   mips_stim_sequencer #(
      .DEPTH(D), .RESET_VECTOR(RV), .RESET_CYCLES(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .run_cycles(run_cycles),
      .expect_v0(expect_v0), .dut_reset(dut_reset), .dut_clk_enable(dut_clk_enable),
      .dut_active(dut_active), .dut_register_v0(dut_register_v0),
      .dut_instr_address(dut_instr_address), .dut_instr_readdata(dut_instr_readdata),
      .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
      .cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] vec();
      return 32'({busy, done, dut_reset, dut_clk_enable});
   endfunction

   function automatic logic [31:0] fetch_model(input logic [31:0] a);
      if (a >= RV && a < RV + 32'(4 * D) && ((a - RV) % 4) == 0)
         return mem_m[(a - RV) / 4];
      return 32'h0;
   endfunction

   // Outcome of one test: which run cycle ends it, how, and the reported count.
   function automatic res_t predict(input int r, input int oor_k, input int fall_k,
                                    input logic [31:0] v0, input logic [31:0] ex);
      res_t p;
      bit   act;
      p = '0;
      for (int k = 1; k <= TO; k++) begin
         act = !(fall_k != 0 && k >= fall_k);
         if (oor_k == k && act) begin
            p.x = N + k; p.chk = 1'b0; p.code = 2'd3; p.cnt = k; return p;
         end
         if (k == TO) begin
            p.x = N + k; p.chk = 1'b0; p.code = 2'd2; p.cnt = k - 1; return p;
         end
         if ((r != 0 && k == r) || (r == 0 && !act && k >= 2)) begin
            p.x = N + k; p.chk = 1'b1; p.code = (v0 == ex) ? 2'd0 : 2'd1; p.cnt = k;
            return p;
         end
      end
      return p;
   endfunction

   task automatic load_word(input int a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = 4'(a);
      load_data = d;
      step();
      load_en   = 1'b0;
      mem_m[a]  = d;
   endtask

   task automatic fetch_chk(input string tag, input logic [31:0] a);
      dut_instr_address = a;
      #1;
      chk(tag, dut_instr_readdata, fetch_model(a));
   endtask

   task automatic run_test(input string tag, input int r, input logic [31:0] ex,
                           input logic [31:0] v0, input int oor_k, input int fall_k,
                           input bit restart, input bit ld_start, input int ld_a,
                           input logic [31:0] ld_d);
      res_t        p;
      int          dn;
      int          k;
      logic [3:0]  ev;
      logic [31:0] efetch;
      p  = predict(r, oor_k, fall_k, v0, ex);
      dn = p.x + int'(p.chk);

      run_cycles      = 16'(r);
      expect_v0       = ex;
      dut_register_v0 = v0;
      dut_active      = 1'b1;
      start           = 1'b1;
      if (ld_start) begin
         load_en = 1'b1; load_addr = 4'(ld_a); load_data = ld_d;
      end
      step();
      start   = 1'b0;
      load_en = 1'b0;
      if (ld_start) mem_m[ld_a] = ld_d;
      run_cycles = 16'($urandom);
      expect_v0  = $urandom;

      for (int i = 1; i <= dn; i++) begin
         k     = i - N;
         start = restart && (i == 1);
         if (k >= 1) begin
            dut_active        = !(fall_k != 0 && k >= fall_k);
            dut_instr_address = (k == oor_k) ? RV + 32'(4 * D) : RV + 32'(4 * ((k - 1) % D));
            efetch            = (k == oor_k) ? 32'h0 : mem_m[(k - 1) % D];
            #1;
            chk($sformatf("%s_fetch%0d", tag, k), dut_instr_readdata, efetch);
         end
         step();
         if (i == dn)                  ev = 4'b0110;
         else if (p.chk && i == p.x)   ev = 4'b1000;
         else if (i < N)               ev = 4'b1011;
         else                          ev = 4'b1001;
         chk($sformatf("%s_ctl%0d", tag, i), vec(), 32'(ev));
      end
      start = 1'b0;
      chk({tag, "_pass"}, 32'(pass), 32'(p.chk && p.code == 2'd0));
      chk({tag, "_code"}, 32'(fail_code), 32'(p.code));
      chk({tag, "_count"}, 32'(cycle_count), 32'(p.cnt));
      step();
      chk({tag, "_idle"}, vec(), 32'h2);
      chk({tag, "_code_held"}, 32'(fail_code), 32'(p.code));
      dut_active        = 1'b1;
      dut_instr_address = RV;
   endtask

   initial begin
      int          mode, r, oor_k, fall_k;
      logic [31:0] v0, ex;

      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
      run_cycles = '0; expect_v0 = '0; dut_active = 1'b1; dut_register_v0 = '0;
      dut_instr_address = RV;
      step();
      step();
      chk("rst_ctl", vec(), 32'h2);
      chk("rst_pass", 32'(pass), 32'h0);
      chk("rst_code", 32'(fail_code), 32'h0);
      chk("rst_count", 32'(cycle_count), 32'h0);
      reset = 1'b0;
      step();
      chk("idle_ctl", vec(), 32'h2);

      load_word(0, 32'h24030F0F);
      load_word(1, 32'h346200FF);
      for (int a = 2; a < D; a++) load_word(a, 32'h0);
      fetch_chk("fetch_w0", RV);
      fetch_chk("fetch_w1", RV + 32'd4);
      fetch_chk("fetch_misaligned", RV + 32'd2);
      fetch_chk("fetch_past_end", RV + 32'(4 * D));
      fetch_chk("fetch_below", RV - 32'd4);
      load_word(15, 32'h3C1F1234);
      fetch_chk("fetch_w15_fresh", RV + 32'd60);

      run_test("match",   3, 32'h00000FFF, 32'h00000FFF, 0, 0, 0, 0, 0, 32'h0);
      run_test("mismatch", 3, 32'h00000FFE, 32'h00000FFF, 0, 0, 0, 0, 0, 32'h0);
      run_test("oor",     3, 32'h00000FFF, 32'h00000FFF, 1, 0, 0, 0, 0, 32'h0);
      run_test("timeout", 0, 32'h00000FFF, 32'h00000FFF, 0, 0, 0, 0, 0, 32'h0);
      run_test("inactive", 0, 32'h00000ABC, 32'h00000ABC, 0, 5, 0, 0, 0, 32'h0);
      run_test("restart", 4, 32'h00000FFF, 32'h00000FFF, 0, 0, 1, 0, 0, 32'h0);
      run_test("ld_start", 4, 32'h00000FFF, 32'h00000FFF, 0, 0, 0, 1, 1, 32'h2402ABCD);

      // Abort mid-run with reset; a load issued during RUN must not land.
      run_cycles = 16'd10; expect_v0 = 32'h0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) step();
      load_en = 1'b1; load_addr = 4'd5; load_data = ~mem_m[5];
      step();
      load_en = 1'b0;
      chk("abort_running", vec(), 32'h9);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_ctl", vec(), 32'h2);
      chk("abort_pass", 32'(pass), 32'h0);
      chk("abort_count", 32'(cycle_count), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("abort_nodone%0d", i), vec(), 32'h2);
      end
      fetch_chk("abort_mem_kept", RV + 32'd20);

      for (int t = 0; t < 8; t++) begin
         load_word(int'($urandom_range(0, D - 1)), $urandom);
         mode = int'($urandom_range(0, 2));
         oor_k = 0; fall_k = 0;
         if (mode == 0) begin
            r = int'($urandom_range(1, 12));
         end else if (mode == 1) begin
            r = 0; fall_k = int'($urandom_range(1, 8));
         end else begin
            r = int'($urandom_range(2, 12)); oor_k = int'($urandom_range(1, r));
         end
         v0 = $urandom;
         ex = ($urandom_range(0, 1) == 1) ? v0 : v0 ^ (32'h1 << $urandom_range(0, 31));
         run_test($sformatf("rnd%0d", t), r, ex, v0, oor_k, fall_k, 1'($urandom_range(0, 1)),
                  0, 0, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
